ex_stage_pipe: RTL and testbench

Registered, parametrised execute stage for the MIPS pipeline, sitting between the ID/EX and EX/MEM boundaries. It computes the ALU result, the branch target and the jump target, and it decides PC redirection. It adds a valid/ready handshake, an iterative multiply/divide unit with HI/LO registers, and a flush input.

---
 rtl/ex_stage_pipe_if.sv | 40 ++++
 rtl/ex_stage_pipe.sv | 246 ++++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pipe_if.sv
// Bus between the ID/EX boundary, the execute stage and the EX/MEM boundary.
// master = upstream/downstream side (drives operands, consumes results); slave = the stage.
interface ex_stage_pipe_if #(
  parameter int XLEN = 32
) ();
  // Handshake: a beat moves on a rising edge only when valid && ready are both high.
  // A producer holds valid and its payload steady until that edge; ready may depend
  // combinationally on the consumer's state but never on the same side's valid.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] incr_pc;
  logic [XLEN-1:0] reg_a;
  logic [XLEN-1:0] reg_b;
  logic [XLEN-1:0] ext_imm;
  logic [25:0]     target;
  logic [5:0]      funct;
  logic [1:0]      alu_op;
  logic            alu_src;
  logic            branch;
  logic            jump;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] to_pc;
  logic            redirect;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output in_valid, incr_pc, reg_a, reg_b, ext_imm, target, funct, alu_op,
           alu_src, branch, jump, out_ready,
    input  in_ready, out_valid, alu_result, to_pc, redirect, hi, lo
  );

  modport slave (
    input  in_valid, incr_pc, reg_a, reg_b, ext_imm, target, funct, alu_op,
           alu_src, branch, jump, out_ready,
    output in_ready, out_valid, alu_result, to_pc, redirect, hi, lo
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// MIPS execute stage: ALU, branch/jump resolution, iterative mult/div with HI/LO,
// registered EX/MEM output with valid/ready handshake and flush.
module ex_stage_pipe #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] DIV0_LO = '1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           flush,
  ex_stage_pipe_if.slave ex,
  output logic           dbgBusy
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateT;

  stateT state, stateNext;

  // Output register and architectural state
  logic            outValid;
  logic [XLEN-1:0] aluResult;
  logic [XLEN-1:0] toPc;
  logic            redirect;
  logic [XLEN-1:0] hiReg;
  logic [XLEN-1:0] loReg;

  // Iterative unit state
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hiAcc;
  logic [XLEN-1:0] loAcc;
  logic [XLEN-1:0] opnd;
  logic            mdIsDiv;
  logic            negHi;
  logic            negLo;
  logic            divZero;
  logic [XLEN-1:0] pcHold;

  // Decode
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] aluRes;
  logic            isMulDiv;
  logic            mdDiv;
  logic            mdSigned;
  logic [XLEN-1:0] pcNext;
  logic            redirNext;
  logic            aNeg;
  logic            bNeg;
  logic [XLEN-1:0] aMag;
  logic [XLEN-1:0] bMag;

  // Iteration / finalisation
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift;
  logic              divGe;
  logic [XLEN-1:0]   divRem;
  logic [XLEN-1:0]   stepHi;
  logic [XLEN-1:0]   stepLo;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   finHi;
  logic [XLEN-1:0]   finLo;

  logic inReady;
  logic accept;

  assign inReady = (state == IDLE) && (!outValid || ex.out_ready) && reset_n;
  assign accept  = ex.in_valid && inReady && !flush;

  always_comb begin
    opB      = ex.alu_src ? ex.ext_imm : ex.reg_b;
    aluRes   = '0;
    isMulDiv = 1'b0;
    mdDiv    = 1'b0;
    mdSigned = 1'b0;
    case (ex.alu_op)
      2'b00:   aluRes = ex.reg_a + opB;
      2'b01:   aluRes = ex.reg_a - opB;
      2'b11:   aluRes = ex.reg_a | opB;
      default: begin
        case (ex.funct)
          FN_ADD:   aluRes = ex.reg_a + opB;
          FN_SUB:   aluRes = ex.reg_a - opB;
          FN_AND:   aluRes = ex.reg_a & opB;
          FN_OR:    aluRes = ex.reg_a | opB;
          FN_XOR:   aluRes = ex.reg_a ^ opB;
          FN_NOR:   aluRes = ~(ex.reg_a | opB);
          FN_SLT:   aluRes = {{(XLEN-1){1'b0}}, ($signed(ex.reg_a) < $signed(opB))};
          FN_SLTU:  aluRes = {{(XLEN-1){1'b0}}, (ex.reg_a < opB)};
          FN_MFHI:  aluRes = hiReg;
          FN_MFLO:  aluRes = loReg;
          FN_MULT:  begin isMulDiv = 1'b1; mdSigned = 1'b1; end
          FN_MULTU: isMulDiv = 1'b1;
          FN_DIV:   begin isMulDiv = 1'b1; mdDiv = 1'b1; mdSigned = 1'b1; end
          FN_DIVU:  begin isMulDiv = 1'b1; mdDiv = 1'b1; end
          default:  aluRes = '0;
        endcase
      end
    endcase
  end

  // Jump wins over branch; the branch compares rs against the selected operand B.
  always_comb begin
    pcNext    = ex.incr_pc;
    redirNext = 1'b0;
    if (ex.jump) begin
      pcNext    = {ex.incr_pc[XLEN-1:28], ex.target, 2'b00};
      redirNext = 1'b1;
    end else if (ex.branch && (ex.reg_a == opB)) begin
      pcNext    = ex.incr_pc + (ex.ext_imm << 2);
      redirNext = 1'b1;
    end
  end

  always_comb begin
    aNeg = mdSigned && ex.reg_a[XLEN-1];
    bNeg = mdSigned && opB[XLEN-1];
    aMag = aNeg ? -ex.reg_a : ex.reg_a;
    bMag = bNeg ? -opB : opB;
  end

  // One shift-add or restoring-subtract step on the magnitudes held in hiAcc:loAcc.
  always_comb begin
    mulSum   = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    divShift = {hiAcc, loAcc[XLEN-1]};
    divGe    = divShift >= {1'b0, opnd};
    divRem   = divShift[XLEN-1:0] - opnd;
    if (mdIsDiv) begin
      stepHi = divGe ? divRem : divShift[XLEN-1:0];
      stepLo = {loAcc[XLEN-2:0], divGe};
    end else begin
      stepHi = mulSum[XLEN:1];
      stepLo = {mulSum[0], loAcc[XLEN-1:1]};
    end
  end

  // Sign correction; a zero divisor leaves |dividend| in hiAcc, so HI restores the dividend.
  always_comb begin
    prodFix = negLo ? -{hiAcc, loAcc} : {hiAcc, loAcc};
    if (mdIsDiv) begin
      finHi = negHi ? -hiAcc : hiAcc;
      finLo = divZero ? DIV0_LO : (negLo ? -loAcc : loAcc);
    end else begin
      finHi = prodFix[2*XLEN-1:XLEN];
      finLo = prodFix[XLEN-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && isMulDiv) stateNext = BUSY;
      BUSY:    if (cnt == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      outValid  <= 1'b0;
      aluResult <= '0;
      toPc      <= '0;
      redirect  <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
      cnt       <= '0;
      hiAcc     <= '0;
      loAcc     <= '0;
      opnd      <= '0;
      mdIsDiv   <= 1'b0;
      negHi     <= 1'b0;
      negLo     <= 1'b0;
      divZero   <= 1'b0;
      pcHold    <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
      cnt      <= '0;
    end else begin
      if (outValid && ex.out_ready) outValid <= 1'b0;
      if (accept) begin
        if (isMulDiv) begin
          cnt     <= CW'(XLEN);
          hiAcc   <= '0;
          loAcc   <= mdDiv ? aMag : bMag;
          opnd    <= mdDiv ? bMag : aMag;
          mdIsDiv <= mdDiv;
          negLo   <= aNeg ^ bNeg;
          negHi   <= mdDiv ? aNeg : (aNeg ^ bNeg);
          divZero <= (opB == '0);
          pcHold  <= ex.incr_pc;
        end else begin
          outValid  <= 1'b1;
          aluResult <= aluRes;
          toPc      <= pcNext;
          redirect  <= redirNext;
        end
      end else if (state == BUSY) begin
        if (cnt != '0) begin
          cnt   <= cnt - 1'b1;
          hiAcc <= stepHi;
          loAcc <= stepLo;
        end else begin
          hiReg     <= finHi;
          loReg     <= finLo;
          outValid  <= 1'b1;
          aluResult <= finLo;
          toPc      <= pcHold;
          redirect  <= 1'b0;
        end
      end
    end
  end

  assign ex.in_ready   = inReady;
  assign ex.out_valid  = outValid;
  assign ex.alu_result = aluResult;
  assign ex.to_pc      = toPc;
  assign ex.redirect   = redirect;
  assign ex.hi         = hiReg;
  assign ex.lo         = loReg;
  assign dbgBusy       = (state == BUSY);

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed cases plus randomized instructions checked
// against an arithmetic reference model through an expected-result queue.
module tb_ex_stage_pipe;
  localparam int XLEN = 32;
  localparam int W    = 1 + 4 * XLEN + 1;  // {is_md, hi, lo, result, to_pc, redirect}

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_DIVU = 6'b011011;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;
  logic dbg_busy;

  ex_stage_pipe_if #(.XLEN(XLEN)) ex_bus ();

  ex_stage_pipe #(.XLEN(XLEN), .DIV0_LO('1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .ex      (ex_bus),
    .dbgBusy (dbg_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] m_hi = '0;
  logic [XLEN-1:0] m_lo = '0;
  int   bp_mode      = 0;      // 0 always ready, 1 random, 2 manual_ready
  logic manual_ready = 1'b1;
  logic [5:0] fn_tab [14];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: instruction semantics written as plain arithmetic.
  function automatic logic [W-1:0] ref_model(
    input logic [31:0] pc, a, rb, imm, input logic [25:0] tgt, input logic [5:0] fn,
    input logic [1:0] op, input logic src, br, jmp, input logic [31:0] cur_hi, cur_lo);
    logic [31:0] b, res, npc, h, l;
    logic        is_md, red;
    logic [63:0] p;
    longint      sa, sb, q, r;
    b = src ? imm : rb;
    res = 0; h = cur_hi; l = cur_lo; is_md = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: res = a + b;
      2'd1: res = a - b;
      2'd3: res = a | b;
      default: begin
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2a: res = (sa < sb) ? 32'd1 : 32'd0;
          6'h2b: res = (a < b) ? 32'd1 : 32'd0;
          6'h10: res = cur_hi;
          6'h12: res = cur_lo;
          6'h18: begin is_md = 1; p = sa * sb; {h, l} = p; end
          6'h19: begin is_md = 1; p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
          6'h1a: begin
            is_md = 1;
            if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
          end
          6'h1b: begin
            is_md = 1;
            if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
            else begin l = a / b; h = a % b; end
          end
          default: res = 0;
        endcase
      end
    endcase
    if (is_md) begin
      res = l; npc = pc; red = 0;
    end else if (jmp) begin
      npc = {pc[31:28], tgt, 2'b00}; red = 1;
    end else if (br && (a == b)) begin
      npc = pc + (imm << 2); red = 1;
    end else begin
      npc = pc; red = 0;
    end
    return {is_md, h, l, res, npc, red};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] pc, a, b, imm, input logic [25:0] tgt,
                       input logic [5:0] fn, input logic [1:0] op,
                       input logic src, br, jmp, input bit commit);
    int guard;
    logic [W-1:0] e;
    @(negedge clock);
    ex_bus.incr_pc = pc;  ex_bus.reg_a  = a;   ex_bus.reg_b   = b;
    ex_bus.ext_imm = imm; ex_bus.target = tgt; ex_bus.funct   = fn;
    ex_bus.alu_op  = op;  ex_bus.alu_src = src; ex_bus.branch = br;
    ex_bus.jump    = jmp; ex_bus.in_valid = 1'b1;
    guard = 0;
    while (!ex_bus.in_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    check_eq("accept", ex_bus.in_ready, 1'b1);
    if (!ex_bus.in_ready) begin
      ex_bus.in_valid = 1'b0;
      return;
    end
    e = ref_model(pc, a, b, imm, tgt, fn, op, src, br, jmp, m_hi, m_lo);
    @(posedge clock);
    #1 ex_bus.in_valid = 1'b0;
    if (commit) begin
      exp_q.push_back(e);
      m_hi = e[128:97];
      m_lo = e[96:65];
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] res, pc, input logic red);
    @(negedge clock);
    check_eq({tag, "_valid"}, ex_bus.out_valid, 1'b1);
    check_eq({tag, "_result"}, ex_bus.alu_result, res);
    check_eq({tag, "_to_pc"}, ex_bus.to_pc, pc);
    check_eq({tag, "_redirect"}, ex_bus.redirect, red);
  endtask

  task automatic wait_out(input string tag);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!ex_bus.out_valid && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check_eq({tag, "_out_valid"}, ex_bus.out_valid, 1'b1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || ex_bus.out_valid) && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  // out_ready changes just after the rising edge so it is stable at both sampling points.
  initial begin
    ex_bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bp_mode == 0)      ex_bus.out_ready = 1'b1;
      else if (bp_mode == 1) ex_bus.out_ready = ($urandom_range(0, 3) != 0);
      else                   ex_bus.out_ready = manual_ready;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && ex_bus.out_valid && ex_bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", ex_bus.out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("sb_result", ex_bus.alu_result, mon_e[64:33]);
          check_eq("sb_to_pc", ex_bus.to_pc, mon_e[32:1]);
          check_eq("sb_redirect", ex_bus.redirect, mon_e[0]);
          check_eq("sb_hi", ex_bus.hi, mon_e[128:97]);
          check_eq("sb_lo", ex_bus.lo, mon_e[96:65]);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int edges;
    logic seen;
    logic [31:0] ra, rb, imm, pc;
    logic [5:0]  fn;
    int idx;

    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
               6'h2b, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b};
    ex_bus.in_valid = 1'b0; ex_bus.incr_pc = '0; ex_bus.reg_a = '0; ex_bus.reg_b = '0;
    ex_bus.ext_imm = '0; ex_bus.target = '0; ex_bus.funct = '0; ex_bus.alu_op = '0;
    ex_bus.alu_src = 1'b0; ex_bus.branch = 1'b0; ex_bus.jump = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_out_valid", ex_bus.out_valid, 1'b0);
    check_eq("rst_result", ex_bus.alu_result, 32'd0);
    check_eq("rst_to_pc", ex_bus.to_pc, 32'd0);
    check_eq("rst_redirect", ex_bus.redirect, 1'b0);
    check_eq("rst_hi", ex_bus.hi, 32'd0);
    check_eq("rst_lo", ex_bus.lo, 32'd0);
    check_eq("rst_in_ready", ex_bus.in_ready, 1'b0);
    check_eq("rst_busy", dbg_busy, 1'b0);
    reset_n = 1'b1;

    // add
    issue(32'h100, 32'd3, 32'd8, 32'd0, 26'd0, FN_ADD, 2'b10, 0, 0, 0, 1);
    expect_now("add", 32'd11, 32'h100, 1'b0);
    // beq taken / not taken
    issue(32'd4, 32'd3, 32'd3, 32'd4, 26'd0, 6'd0, 2'b01, 0, 1, 0, 1);
    expect_now("beq_taken", 32'd0, 32'h14, 1'b1);
    issue(32'd4, 32'd8, 32'd3, 32'd4, 26'd0, 6'd0, 2'b01, 0, 1, 0, 1);
    expect_now("beq_not_taken", 32'd5, 32'd4, 1'b0);
    // jump beats a branch that would also be taken
    issue(32'h0040_0004, 32'd5, 32'd5, 32'd8, 26'h010000E, 6'd0, 2'b00, 0, 1, 1, 1);
    expect_now("jump", 32'd10, 32'h0040_0038, 1'b1);

    // signed mult latency and in_ready
    issue(32'h200, 32'hFFFF_FFFD, 32'd7, 32'd0, 26'd0, FN_MULT, 2'b10, 0, 0, 0, 1);
    edges = 0;
    seen  = 1'b0;
    @(negedge clock);
    while (!ex_bus.out_valid && edges < 100) begin
      seen |= ex_bus.in_ready;
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    check_eq("mult_latency", edges, 33);
    check_eq("mult_in_ready_low", seen, 1'b0);
    check_eq("mult_lo", ex_bus.lo, 32'hFFFF_FFEB);
    check_eq("mult_hi", ex_bus.hi, 32'hFFFF_FFFF);
    check_eq("mult_result", ex_bus.alu_result, 32'hFFFF_FFEB);
    issue(32'h204, 32'd0, 32'd0, 32'd0, 26'd0, FN_MFHI, 2'b10, 0, 0, 0, 1);
    expect_now("mfhi", 32'hFFFF_FFFF, 32'h204, 1'b0);

    // division
    issue(32'h300, -32'sd7, 32'd2, 32'd0, 26'd0, FN_DIV, 2'b10, 0, 0, 0, 1);
    wait_out("div");
    check_eq("div_lo", ex_bus.lo, 32'hFFFF_FFFD);
    check_eq("div_hi", ex_bus.hi, 32'hFFFF_FFFF);
    issue(32'h304, 32'd10, 32'd0, 32'd0, 26'd0, FN_DIVU, 2'b10, 0, 0, 0, 1);
    wait_out("divu0");
    check_eq("divu0_lo", ex_bus.lo, 32'hFFFF_FFFF);
    check_eq("divu0_hi", ex_bus.hi, 32'd10);
    drain();

    // backpressure
    manual_ready = 1'b0;
    bp_mode = 2;
    @(posedge clock);
    issue(32'h400, 32'd20, 32'd22, 32'd0, 26'd0, FN_ADD, 2'b10, 0, 0, 0, 1);
    repeat (5) begin
      @(negedge clock);
      check_eq("bp_valid", ex_bus.out_valid, 1'b1);
      check_eq("bp_result", ex_bus.alu_result, 32'd42);
      check_eq("bp_to_pc", ex_bus.to_pc, 32'h400);
      check_eq("bp_redirect", ex_bus.redirect, 1'b0);
      check_eq("bp_in_ready", ex_bus.in_ready, 1'b0);
    end
    manual_ready = 1'b1;
    @(posedge clock);
    #2 bp_mode = 0;
    drain();

    // flush 10 cycles into a div
    issue(32'h500, 32'd100, 32'd3, 32'd0, 26'd0, FN_DIV, 2'b10, 0, 0, 0, 0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    check_eq("flush_out_valid", ex_bus.out_valid, 1'b0);
    check_eq("flush_idle", dbg_busy, 1'b0);
    check_eq("flush_hi", ex_bus.hi, 32'd10);
    check_eq("flush_lo", ex_bus.lo, m_lo);
    check_eq("flush_in_ready", ex_bus.in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen |= ex_bus.out_valid;
    end
    check_eq("flush_no_ghost", seen, 1'b0);

    // randomized traffic with random backpressure
    bp_mode = 1;
    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(0, 15);
      fn  = (idx < 14) ? fn_tab[idx] : 6'($urandom);
      ra  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      issue(pc, ra, rb, imm, 26'($urandom), fn, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0), 1);
    end
    drain();
    bp_mode = 0;

    // reset in the middle of a multiply
    issue(32'h600, 32'd5, 32'd6, 32'd0, 26'd0, FN_MULT, 2'b10, 0, 0, 0, 0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("midrst_hi", ex_bus.hi, 32'd0);
    check_eq("midrst_lo", ex_bus.lo, 32'd0);
    check_eq("midrst_out_valid", ex_bus.out_valid, 1'b0);
    check_eq("midrst_in_ready", ex_bus.in_ready, 1'b0);
    check_eq("midrst_busy", dbg_busy, 1'b0);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    issue(32'h700, 32'd0, 32'd0, 32'd0, 26'd0, FN_MFLO, 2'b10, 0, 0, 0, 1);
    expect_now("post_rst_mflo", 32'd0, 32'h700, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
